sys_reg_file: RTL and testbench

- Configuration/operand register file sitting directly downstream of the system controller on the main (reference) clock domain.
- Accepts single-cycle write and read strobes with a 4-bit address.
- Returns read data with a one-cycle valid pulse.
- Continuously exports registers 0..3 as ALU operand A, ALU operand B, UART config and clock-divider ratio.
- Flags illegal accesses: out-of-range address, write to a protected register, simultaneous write and read.

---
 rtl/sys_reg_file.sv | 144 ++++++++++++++
 tb/tb_sys_reg_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sys_reg_file.sv
// Configuration/operand register file on the reference clock domain.
// Single-cycle read/write strobes, registered read response, and one-cycle illegal-access flag.
module sys_reg_file #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            DEPTH      = 16,
  parameter logic [DEPTH-1:0]       WP_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0]  REG2_RST   = 8'b1000_0001,
  parameter logic [DATA_WIDTH-1:0]  REG3_RST   = 8'd32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdData_Valid,
  output logic                  Acc_Err,
  output logic [DATA_WIDTH-1:0] REG0,
  output logic [DATA_WIDTH-1:0] REG1,
  output logic [DATA_WIDTH-1:0] REG2,
  output logic [DATA_WIDTH-1:0] REG3
);

  localparam int unsigned IDX_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_RESP  = 2'd1,
    ERR_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;
  state_t                state_r;
  state_t                state_next_s;

  logic                  addr_ok_s;
  logic                  wp_hit_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  acc_err_s;
  logic [IDX_W-1:0]      addr_idx_s;

  // Power-on contents: config/divider registers get their defaults, the rest clear.
  function automatic logic [DATA_WIDTH-1:0] rst_value(input int unsigned idx);
    logic [DATA_WIDTH-1:0] val;
    case (idx)
      32'd2:   val = REG2_RST;
      32'd3:   val = REG3_RST;
      default: val = {DATA_WIDTH{1'b0}};
    endcase
    return val;
  endfunction

  // Access decode: range check at full address width, protection, legality.
  always_comb begin
    addr_ok_s  = (32'(Address) < DEPTH);
    addr_idx_s = IDX_W'(Address);
    if (addr_ok_s) begin
      wp_hit_s = WP_MASK[addr_idx_s];
    end else begin
      wp_hit_s = 1'b0;
    end
    wr_ok_s   = WrEn & addr_ok_s & ~wp_hit_s;
    rd_ok_s   = RdEn & ~WrEn & addr_ok_s;
    acc_err_s = (WrEn | RdEn) & (~addr_ok_s | (WrEn & RdEn) | (WrEn & wp_hit_s));
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_reg
      // Storage cell g: written only by a legal, unprotected write to its index.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          mem_r[g] <= rst_value(g);
        end else if (wr_ok_s && (addr_idx_s == IDX_W'(g))) begin
          mem_r[g] <= WrData;
        end else begin
          mem_r[g] <= mem_r[g];
        end
      end
    end
  endgenerate

  // Read data holds between legal reads; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_ok_s) begin
      rd_data_r <= mem_r[addr_idx_s];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  // Response FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Every state reacts to a new strobe the same way, so responses chain back-to-back.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE, RD_RESP, ERR_RESP: begin
        if (rd_ok_s) begin
          state_next_s = RD_RESP;
        end else if (acc_err_s) begin
          state_next_s = ERR_RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Response pulses decoded from the registered state.
  always_comb begin
    RdData_Valid = 1'b0;
    Acc_Err      = 1'b0;
    case (state_r)
      RD_RESP:  RdData_Valid = 1'b1;
      ERR_RESP: Acc_Err      = 1'b1;
      default: begin
        RdData_Valid = 1'b0;
        Acc_Err      = 1'b0;
      end
    endcase
  end

  assign RdData = rd_data_r;
  assign REG0   = mem_r[0];
  assign REG1   = mem_r[1];
  assign REG2   = mem_r[2];
  assign REG3   = mem_r[3];

endmodule

// File: tb/tb_sys_reg_file.sv
// Bench for sys_reg_file: two configurations driven in lockstep and compared
// against an array-based reference model, with directed and random accesses.
module tb_sys_reg_file;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;

  logic [7:0] rd_a, reg0_a, reg1_a, reg2_a, reg3_a;
  logic       val_a, err_a;
  logic [7:0] rd_b, reg0_b, reg1_b, reg2_b, reg3_b;
  logic       val_b, err_b;

  int checks = 0;
  int errors = 0;

  // Reference model: k=0 full 16-entry unprotected, k=1 8-entry with register 3 protected.
  logic [7:0]  mem_m [2][16];
  logic [7:0]  rd_m  [2];
  logic        val_m [2];
  logic        err_m [2];
  int          depth_m [2] = '{16, 8};
  logic [15:0] wp_m    [2] = '{16'h0000, 16'h0008};

  always #5 CLK = ~CLK;

  sys_reg_file u_dut_a (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(rd_a), .RdData_Valid(val_a), .Acc_Err(err_a),
    .REG0(reg0_a), .REG1(reg1_a), .REG2(reg2_a), .REG3(reg3_a)
  );

  sys_reg_file #(.DEPTH(8), .WP_MASK(8'h08)) u_dut_b (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(rd_b), .RdData_Valid(val_b), .Acc_Err(err_b),
    .REG0(reg0_b), .REG1(reg1_b), .REG2(reg2_b), .REG3(reg3_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mem_m[k][i] = 8'h00;
      mem_m[k][2] = 8'h81;
      mem_m[k][3] = 8'h20;
      rd_m[k]  = 8'h00;
      val_m[k] = 1'b0;
      err_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic we, input logic re, input int addr, input logic [7:0] data);
    for (int k = 0; k < 2; k++) begin
      bit in_range;
      bit prot;
      in_range = (addr < depth_m[k]);
      prot     = in_range && wp_m[k][addr];
      val_m[k] = re && !we && in_range;
      err_m[k] = (we || re) && (!in_range || (we && re) || (we && prot));
      if (val_m[k]) rd_m[k] = mem_m[k][addr];
      if (we && in_range && !prot) mem_m[k][addr] = data;
    end
  endtask

  task automatic check_all(input string tag);
    check_val($sformatf("%s.a.rd", tag),    rd_a,   rd_m[0]);
    check_val($sformatf("%s.a.valid", tag), val_a,  val_m[0]);
    check_val($sformatf("%s.a.err", tag),   err_a,  err_m[0]);
    check_val($sformatf("%s.a.reg0", tag),  reg0_a, mem_m[0][0]);
    check_val($sformatf("%s.a.reg1", tag),  reg1_a, mem_m[0][1]);
    check_val($sformatf("%s.a.reg2", tag),  reg2_a, mem_m[0][2]);
    check_val($sformatf("%s.a.reg3", tag),  reg3_a, mem_m[0][3]);
    check_val($sformatf("%s.b.rd", tag),    rd_b,   rd_m[1]);
    check_val($sformatf("%s.b.valid", tag), val_b,  val_m[1]);
    check_val($sformatf("%s.b.err", tag),   err_b,  err_m[1]);
    check_val($sformatf("%s.b.reg0", tag),  reg0_b, mem_m[1][0]);
    check_val($sformatf("%s.b.reg1", tag),  reg1_b, mem_m[1][1]);
    check_val($sformatf("%s.b.reg2", tag),  reg2_b, mem_m[1][2]);
    check_val($sformatf("%s.b.reg3", tag),  reg3_b, mem_m[1][3]);
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic cycle(input string tag, input logic we, input logic re, input int addr, input logic [7:0] data);
    WrEn    = we;
    RdEn    = re;
    Address = addr[3:0];
    WrData  = data;
    @(posedge CLK);
    model_step(we, re, addr, data);
    @(negedge CLK);
    check_all(tag);
  endtask

  initial begin
    RST = 1'b1; WrEn = 1'b0; RdEn = 1'b0; Address = 4'd0; WrData = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_all("reset");
    check_val("reset.reg2_const", reg2_a, 8'h81);
    check_val("reset.reg3_const", reg3_a, 8'h20);

    cycle("wr5", 1'b1, 1'b0, 5, 8'h5A);
    cycle("rd5", 1'b0, 1'b1, 5, 8'h00);
    check_val("rd5.data", rd_a, 8'h5A);
    check_val("rd5.valid", val_a, 1'b1);
    cycle("idle1", 1'b0, 1'b0, 0, 8'h00);
    check_val("rd5.pulse_end", val_a, 1'b0);

    cycle("wr0", 1'b1, 1'b0, 0, 8'h12);
    check_val("wr0.reg0", reg0_a, 8'h12);
    cycle("wr1", 1'b1, 1'b0, 1, 8'h34);
    check_val("wr1.reg1", reg1_a, 8'h34);
    cycle("rd3", 1'b0, 1'b1, 3, 8'h00);
    check_val("rd3.data", rd_a, 8'h20);

    cycle("wr3prot", 1'b1, 1'b0, 3, 8'h07);
    check_val("wr3prot.b.reg3", reg3_b, 8'h20);
    check_val("wr3prot.b.err", err_b, 1'b1);
    check_val("wr3prot.a.reg3", reg3_a, 8'h07);
    cycle("rd9", 1'b0, 1'b1, 9, 8'h00);
    check_val("rd9.b.valid", val_b, 1'b0);
    check_val("rd9.b.err", err_b, 1'b1);
    check_val("rd9.b.rd_hold", rd_b, 8'h20);

    cycle("wrrd2", 1'b1, 1'b1, 2, 8'hC3);
    check_val("wrrd2.reg2", reg2_a, 8'hC3);
    check_val("wrrd2.valid", val_a, 1'b0);
    check_val("wrrd2.err", err_a, 1'b1);
    cycle("idle2", 1'b0, 1'b0, 0, 8'h00);
    check_val("wrrd2.err_once", err_a, 1'b0);

    cycle("b2b0", 1'b0, 1'b1, 0, 8'h00);
    cycle("b2b1", 1'b0, 1'b1, 1, 8'h00);
    check_val("b2b1.valid", val_a, 1'b1);
    check_val("b2b1.data", rd_a, 8'h34);

    // Reset lands between a read strobe and the edge that would answer it.
    WrEn = 1'b0; RdEn = 1'b1; Address = 4'd4;
    #2 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; RdEn = 1'b0;
    model_reset();
    check_all("midrst");
    cycle("midrst_idle", 1'b0, 1'b0, 0, 8'h00);
    check_val("midrst.valid", val_a, 1'b0);

    for (int n = 0; n < 600; n++) begin
      logic we;
      logic re;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      cycle($sformatf("rand%0d", n), we, re, int'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
